eth_crc32_stream: RTL and testbench

Parametrised streaming Ethernet FCS engine. It computes IEEE 802.3 CRC-32 over a frame delivered as multi-byte beats with a byte-valid mask on the last beat, and it can check a received frame including its FCS. It sits between the GMII-side TX/RX handlers and the frame buffers. TX uses it to generate the FCS to append; RX uses it to flag bad frames. It generalises the fixed 8-bit single-step CRC-32 next-state function to N bytes per clock, with framing, a handshake and check mode.

---
 rtl/eth_crc32_stream_if.sv | 42 ++++
 rtl/eth_crc32_stream.sv | 156 +++++++++++++++
 tb/tb_eth_crc32_stream.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/eth_crc32_stream_if.sv
// Purpose : handshake and result bundle between a frame source and the CRC-32 engine.
// Latency : n/a (wires only).
// Backpressure: in_ready qualifies in_valid; results are strobed by done_port.
//
// Signals:
//   start_port  - one-cycle pulse opening a new frame
//   in_data     - beat payload, lane 0 (bits 7:0) first on the wire
//   in_keep     - byte-valid mask, meaningful on the last beat only
//   in_valid    - beat valid
//   in_last     - final beat of the frame
//   in_ready    - engine is accepting beats
//   done_port   - one-cycle pulse, result valid
//   return_port - final FCS, bits 7:0 transmitted first
//   crc_ok      - residue check result (check mode)
//   byte_count  - bytes consumed in the frame (saturating)
interface eth_crc32_stream_if #(
  parameter int DATA_BYTES = 1,
  parameter int COUNT_W    = 16
);
  logic                    start_port;
  logic [8*DATA_BYTES-1:0] in_data;
  logic [DATA_BYTES-1:0]   in_keep;
  logic                    in_valid;
  logic                    in_last;
  logic                    in_ready;
  logic                    done_port;
  logic [31:0]             return_port;
  logic                    crc_ok;
  logic [COUNT_W-1:0]      byte_count;

  // Frame source side.
  modport master (
    output start_port, in_data, in_keep, in_valid, in_last,
    input  in_ready, done_port, return_port, crc_ok, byte_count
  );

  // CRC engine side.
  modport slave (
    input  start_port, in_data, in_keep, in_valid, in_last,
    output in_ready, done_port, return_port, crc_ok, byte_count
  );
endinterface

// File: rtl/eth_crc32_stream.sv
// Purpose : streaming IEEE 802.3 CRC-32 (FCS) engine, DATA_BYTES bytes per clock, generate or check.
// Latency : done_port rises the cycle after the last beat is accepted; one beat per clock sustained.
// Backpressure: in_ready is high only in RUN; the engine never stalls a beat while running.
//
// Ports:
//   clock, reset - single clock, synchronous active-high reset (priority over everything)
//   bus (slave)  - start/beat inputs, in_ready, done_port, return_port, crc_ok, byte_count
module eth_crc32_stream #(
  parameter int DATA_BYTES = 1,
  parameter int COUNT_W    = 16
) (
  input  logic                clock,
  input  logic                reset,
  eth_crc32_stream_if.slave   bus
);

  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] POLY_REF = 32'hEDB8_8320;
  // ~residue of a frame that carries its own correct FCS (residue 0xDEBB20E3).
  localparam logic [31:0] GOOD_FCS = 32'h2144_DF1C;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          crc_q, crc_d;
  logic [31:0]          result_q, result_d;
  logic                 ok_q, ok_d;
  logic [COUNT_W-1:0]   cnt_q, cnt_d;

  logic                 abort;
  logic                 beat;
  logic [31:0]          crc_base;
  logic [COUNT_W-1:0]   cnt_base;
  logic [DATA_BYTES-1:0] lane_en;
  logic [3:0]           lane_cnt;
  logic                 lane_run;
  logic [31:0]          crc_step;
  logic [COUNT_W:0]     cnt_sum;
  logic [COUNT_W-1:0]   cnt_step;

  // One reflected CRC-32 byte step, LSB of the byte shifted in first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in ^ {24'h0, d};
    for (int b = 0; b < 8; b++) begin
      if (c[0]) c = (c >> 1) ^ POLY_REF;
      else      c = c >> 1;
    end
    return c;
  endfunction

  // A start in RUN restarts the frame; a beat in the same cycle belongs to the new frame,
  // so the step logic works from the re-initialised values rather than the registers.
  always_comb begin
    abort    = (state_q == RUN) && bus.start_port;
    beat     = (state_q == RUN) && bus.in_valid;
    crc_base = abort ? CRC_INIT : crc_q;
    cnt_base = abort ? '0 : cnt_q;
  end

  // Lane enables: every lane on a non-last beat; on the last beat only the leading run of
  // set keep bits, so a hole in the mask cuts off everything above it.
  always_comb begin
    lane_en  = '0;
    lane_cnt = '0;
    lane_run = 1'b1;
    for (int i = 0; i < DATA_BYTES; i++) begin
      lane_run   = lane_run && (!bus.in_last || bus.in_keep[i]);
      lane_en[i] = lane_run;
      lane_cnt   = lane_cnt + {3'b000, lane_run};
    end
  end

  // Unrolled chain of byte steps, lane 0 first.
  always_comb begin
    crc_step = crc_base;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (lane_en[i]) crc_step = crc_byte(crc_step, bus.in_data[8*i +: 8]);
    end
  end

  // Saturating byte counter: one extra bit catches the wrap.
  always_comb begin
    cnt_sum  = {1'b0, cnt_base} + {{(COUNT_W-3){1'b0}}, lane_cnt};
    cnt_step = cnt_sum[COUNT_W] ? {COUNT_W{1'b1}} : cnt_sum[COUNT_W-1:0];
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    crc_d    = crc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ok_d     = ok_q;
    case (state_q)
      IDLE: begin
        if (bus.start_port) begin
          state_d = RUN;
          crc_d   = CRC_INIT;
          cnt_d   = '0;
        end
      end
      RUN: begin
        crc_d = crc_base;
        cnt_d = cnt_base;
        if (beat) begin
          crc_d = crc_step;
          cnt_d = cnt_step;
          if (bus.in_last) begin
            state_d  = DONE;
            // Captured here so the result is already on return_port during DONE and
            // simply holds afterwards.
            result_d = ~crc_step;
            ok_d     = (~crc_step == GOOD_FCS);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (bus.start_port) begin
          state_d = RUN;
          crc_d   = CRC_INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      crc_q    <= CRC_INIT;
      cnt_q    <= '0;
      result_q <= '0;
      ok_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      crc_q    <= crc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ok_q     <= ok_d;
    end
  end

  assign bus.in_ready    = (state_q == RUN);
  assign bus.done_port   = (state_q == DONE);
  assign bus.return_port = result_q;
  assign bus.crc_ok      = ok_q;
  assign bus.byte_count  = cnt_q;

endmodule

// File: tb/tb_eth_crc32_stream.sv
// Purpose : directed self-checking bench for eth_crc32_stream at 1, 4 and 8 bytes per beat.
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpressure: engine never stalls in RUN, so beats are driven one per clock.
module tb_eth_crc32_stream;

  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  eth_crc32_stream_if #(.DATA_BYTES(1), .COUNT_W(16)) b1 ();
  eth_crc32_stream_if #(.DATA_BYTES(4), .COUNT_W(16)) b4 ();
  eth_crc32_stream_if #(.DATA_BYTES(8), .COUNT_W(16)) b8 ();

  eth_crc32_stream #(.DATA_BYTES(1), .COUNT_W(16)) u1 (.clock(clock), .reset(reset), .bus(b1));
  eth_crc32_stream #(.DATA_BYTES(4), .COUNT_W(16)) u4 (.clock(clock), .reset(reset), .bus(b4));
  eth_crc32_stream #(.DATA_BYTES(8), .COUNT_W(16)) u8 (.clock(clock), .reset(reset), .bus(b8));

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_all;
    b1.start_port = 0; b1.in_data = '0; b1.in_keep = '0; b1.in_valid = 0; b1.in_last = 0;
    b4.start_port = 0; b4.in_data = '0; b4.in_keep = '0; b4.in_valid = 0; b4.in_last = 0;
    b8.start_port = 0; b8.in_data = '0; b8.in_keep = '0; b8.in_valid = 0; b8.in_last = 0;
  endtask

  task automatic beat1(input logic [7:0] d, input logic k, input logic l, input logic s);
    b1.start_port = s; b1.in_valid = 1; b1.in_data = d; b1.in_keep = k; b1.in_last = l;
    tick();
    idle_all();
  endtask

  task automatic beat4(input logic [31:0] d, input logic [3:0] k, input logic l, input logic s);
    b4.start_port = s; b4.in_valid = 1; b4.in_data = d; b4.in_keep = k; b4.in_last = l;
    tick();
    idle_all();
  endtask

  task automatic beat8(input logic [63:0] d, input logic [7:0] k, input logic l, input logic s);
    b8.start_port = s; b8.in_valid = 1; b8.in_data = d; b8.in_keep = k; b8.in_last = l;
    tick();
    idle_all();
  endtask

  task automatic test_reset;
    reset = 1;
    idle_all();
    tick(); tick();
    checks++; if (b4.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", b4.in_ready); end
    checks++; if (b4.done_port !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", b4.done_port); end
    checks++; if (b4.return_port !== 32'h0) begin failures++; $display("FAIL reset_return got=%h exp=0", b4.return_port); end
    checks++; if (b4.crc_ok !== 1'b0) begin failures++; $display("FAIL reset_crc_ok got=%b exp=0", b4.crc_ok); end
    checks++; if (b4.byte_count !== 16'h0) begin failures++; $display("FAIL reset_count got=%h exp=0", b4.byte_count); end
    reset = 0;
    // A valid beat in IDLE must be ignored.
    b4.in_valid = 1; b4.in_data = 32'h11223344; b4.in_keep = 4'hF; b4.in_last = 1;
    tick();
    idle_all();
    checks++; if (b4.done_port !== 1'b0 || b4.in_ready !== 1'b0) begin failures++; $display("FAIL idle_ignores_beat done=%b ready=%b exp=0,0", b4.done_port, b4.in_ready); end
  endtask

  task automatic test_crc_basic;
    b4.start_port = 1; tick(); idle_all();
    checks++; if (b4.in_ready !== 1'b1) begin failures++; $display("FAIL run_in_ready got=%b exp=1", b4.in_ready); end
    beat4(32'h34333231, 4'hF, 0, 0);
    beat4(32'h38373635, 4'hF, 0, 0);
    checks++; if (b4.done_port !== 1'b0) begin failures++; $display("FAIL basic_early_done got=%b exp=0", b4.done_port); end
    beat4(32'h00000039, 4'h1, 1, 0);
    checks++; if (b4.done_port !== 1'b1) begin failures++; $display("FAIL basic_done got=%b exp=1", b4.done_port); end
    checks++; if (b4.return_port !== 32'hCBF43926) begin failures++; $display("FAIL basic_fcs got=%h exp=cbf43926", b4.return_port); end
    checks++; if (b4.byte_count !== 16'd9) begin failures++; $display("FAIL basic_count got=%0d exp=9", b4.byte_count); end
    checks++; if (b4.in_ready !== 1'b0) begin failures++; $display("FAIL done_in_ready got=%b exp=0", b4.in_ready); end
    tick();
    checks++; if (b4.done_port !== 1'b0) begin failures++; $display("FAIL done_one_cycle got=%b exp=0", b4.done_port); end
    checks++; if (b4.return_port !== 32'hCBF43926 || b4.byte_count !== 16'd9) begin failures++; $display("FAIL basic_hold fcs=%h cnt=%0d exp=cbf43926,9", b4.return_port, b4.byte_count); end
  endtask

  task automatic test_single_byte;
    b1.start_port = 1; tick(); idle_all();
    beat1(8'h00, 1'b1, 1, 0);
    checks++; if (b1.done_port !== 1'b1 || b1.return_port !== 32'hD202EF8D) begin failures++; $display("FAIL byte00 done=%b fcs=%h exp=1,d202ef8d", b1.done_port, b1.return_port); end
    checks++; if (b1.byte_count !== 16'd1) begin failures++; $display("FAIL byte00_count got=%0d exp=1", b1.byte_count); end
    tick();
    b1.start_port = 1; tick(); idle_all();
    beat1(8'hFF, 1'b0, 1, 0);
    checks++; if (b1.done_port !== 1'b1 || b1.return_port !== 32'h0) begin failures++; $display("FAIL empty_frame done=%b fcs=%h exp=1,00000000", b1.done_port, b1.return_port); end
    checks++; if (b1.byte_count !== 16'd0) begin failures++; $display("FAIL empty_count got=%0d exp=0", b1.byte_count); end
    tick();
  endtask

  task automatic test_check_mode;
    b4.start_port = 1; tick(); idle_all();
    beat4(32'h34333231, 4'hF, 0, 0);
    beat4(32'h38373635, 4'hF, 0, 0);
    beat4(32'hF4392639, 4'hF, 0, 0);
    beat4(32'h000000CB, 4'h1, 1, 0);
    checks++; if (b4.crc_ok !== 1'b1) begin failures++; $display("FAIL check_good_ok got=%b exp=1", b4.crc_ok); end
    checks++; if (b4.return_port !== 32'h2144DF1C) begin failures++; $display("FAIL check_good_fcs got=%h exp=2144df1c", b4.return_port); end
    checks++; if (b4.byte_count !== 16'd13) begin failures++; $display("FAIL check_count got=%0d exp=13", b4.byte_count); end
    tick();
    b4.start_port = 1; tick(); idle_all();
    beat4(32'h34333230, 4'hF, 0, 0);
    beat4(32'h38373635, 4'hF, 0, 0);
    beat4(32'hF4392639, 4'hF, 0, 0);
    beat4(32'h000000CB, 4'h1, 1, 0);
    checks++; if (b4.crc_ok !== 1'b0 || b4.done_port !== 1'b1) begin failures++; $display("FAIL check_bad_ok ok=%b done=%b exp=0,1", b4.crc_ok, b4.done_port); end
    tick();
  endtask

  task automatic test_stall;
    b8.start_port = 1; tick(); idle_all();
    beat8(64'h3837363534333231, 8'hFF, 0, 0);
    for (int i = 0; i < 3; i++) begin
      b8.in_valid = 0; b8.in_data = 64'hA5A5A5A5A5A5A5A5; b8.in_keep = 8'hFF; b8.in_last = 1;
      tick();
      checks++; if (b8.done_port !== 1'b0 || b8.in_ready !== 1'b1) begin failures++; $display("FAIL stall_%0d done=%b ready=%b exp=0,1", i, b8.done_port, b8.in_ready); end
    end
    idle_all();
    beat8(64'h0000000000000039, 8'h01, 1, 0);
    checks++; if (b8.done_port !== 1'b1 || b8.return_port !== 32'hCBF43926) begin failures++; $display("FAIL stall_fcs done=%b fcs=%h exp=1,cbf43926", b8.done_port, b8.return_port); end
    checks++; if (b8.byte_count !== 16'd9) begin failures++; $display("FAIL stall_count got=%0d exp=9", b8.byte_count); end
    tick();
  endtask

  task automatic test_keep_holes;
    b4.start_port = 1; tick(); idle_all();
    beat4(32'h34333231, 4'hF, 0, 0);
    beat4(32'h38373635, 4'hF, 0, 0);
    beat4(32'hAAAAAA39, 4'b1101, 1, 0);
    checks++; if (b4.return_port !== 32'hCBF43926) begin failures++; $display("FAIL keep_hole_fcs got=%h exp=cbf43926", b4.return_port); end
    checks++; if (b4.byte_count !== 16'd9) begin failures++; $display("FAIL keep_hole_count got=%0d exp=9", b4.byte_count); end
    tick();
  endtask

  task automatic test_abort;
    b4.start_port = 1; tick(); idle_all();
    beat4(32'hDEADBEEF, 4'hF, 0, 0);
    b4.start_port = 1; tick(); idle_all();
    checks++; if (b4.done_port !== 1'b0 || b4.byte_count !== 16'd0) begin failures++; $display("FAIL abort_clear done=%b cnt=%0d exp=0,0", b4.done_port, b4.byte_count); end
    beat4(32'h12345678, 4'hF, 0, 0);
    // Start coincident with a beat: the beat opens the new frame.
    beat4(32'h34333231, 4'hF, 0, 1);
    checks++; if (b4.done_port !== 1'b0 || b4.byte_count !== 16'd4) begin failures++; $display("FAIL abort_with_beat done=%b cnt=%0d exp=0,4", b4.done_port, b4.byte_count); end
    beat4(32'h38373635, 4'hF, 0, 0);
    beat4(32'h00000039, 4'h1, 1, 0);
    checks++; if (b4.done_port !== 1'b1 || b4.return_port !== 32'hCBF43926 || b4.byte_count !== 16'd9) begin failures++; $display("FAIL abort_result done=%b fcs=%h cnt=%0d exp=1,cbf43926,9", b4.done_port, b4.return_port, b4.byte_count); end
    tick();
    // Reset in the middle of a frame.
    b4.start_port = 1; tick(); idle_all();
    beat4(32'h34333231, 4'hF, 0, 0);
    b4.in_valid = 1; b4.in_data = 32'h38373635; b4.in_keep = 4'hF; b4.in_last = 1;
    reset = 1;
    tick();
    reset = 0;
    idle_all();
    checks++; if (b4.in_ready !== 1'b0 || b4.done_port !== 1'b0) begin failures++; $display("FAIL midreset_ctl ready=%b done=%b exp=0,0", b4.in_ready, b4.done_port); end
    checks++; if (b4.return_port !== 32'h0 || b4.crc_ok !== 1'b0 || b4.byte_count !== 16'd0) begin failures++; $display("FAIL midreset_out fcs=%h ok=%b cnt=%0d exp=0,0,0", b4.return_port, b4.crc_ok, b4.byte_count); end
    tick();
    checks++; if (b4.done_port !== 1'b0) begin failures++; $display("FAIL midreset_no_done got=%b exp=0", b4.done_port); end
  endtask

  task automatic test_back_to_back;
    b4.start_port = 1; tick(); idle_all();
    beat4(32'h34333231, 4'hF, 0, 0);
    beat4(32'h38373635, 4'hF, 0, 0);
    beat4(32'h00000039, 4'h1, 1, 0);
    checks++; if (b4.done_port !== 1'b1 || b4.return_port !== 32'hCBF43926) begin failures++; $display("FAIL b2b_first done=%b fcs=%h exp=1,cbf43926", b4.done_port, b4.return_port); end
    b4.start_port = 1; tick(); idle_all();
    checks++; if (b4.in_ready !== 1'b1 || b4.done_port !== 1'b0 || b4.byte_count !== 16'd0) begin failures++; $display("FAIL b2b_restart ready=%b done=%b cnt=%0d exp=1,0,0", b4.in_ready, b4.done_port, b4.byte_count); end
    beat4(32'h00000000, 4'h1, 1, 0);
    checks++; if (b4.done_port !== 1'b1 || b4.return_port !== 32'hD202EF8D || b4.byte_count !== 16'd1) begin failures++; $display("FAIL b2b_second done=%b fcs=%h cnt=%0d exp=1,d202ef8d,1", b4.done_port, b4.return_port, b4.byte_count); end
    tick();
  endtask

  task automatic test_saturation;
    b8.start_port = 1; tick(); idle_all();
    for (int i = 0; i < 8191; i++) beat8(64'h0, 8'hFF, 0, 0);
    checks++; if (b8.byte_count !== 16'hFFF8) begin failures++; $display("FAIL sat_below got=%h exp=fff8", b8.byte_count); end
    beat8(64'h0, 8'hFF, 0, 0);
    checks++; if (b8.byte_count !== 16'hFFFF) begin failures++; $display("FAIL sat_wrap got=%h exp=ffff", b8.byte_count); end
    beat8(64'h0, 8'h07, 1, 0);
    checks++; if (b8.done_port !== 1'b1 || b8.byte_count !== 16'hFFFF) begin failures++; $display("FAIL sat_final done=%b cnt=%h exp=1,ffff", b8.done_port, b8.byte_count); end
    tick();
  endtask

  initial begin
    reset = 1;
    idle_all();
    test_reset();
    test_crc_basic();
    test_single_byte();
    test_check_mode();
    test_stall();
    test_keep_holes();
    test_abort();
    test_back_to_back();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
